// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through a synchronous instruction memory,
// hands each instruction to the control unit and waits for its completion.
module fetch_sequencer #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LAST_ADDR = 31
) (
    input  logic              pclock,
    input  logic              resetn,
    input  logic              start,
    output logic [ADDR_W-1:0] memaddr,
    input  logic [DATA_W-1:0] memdata,
    output logic [DATA_W-1:0] instr,
    output logic              run,
    input  logic              done,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jumpaddr,
    output logic              busy,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        ISSUE,
        EXEC,
        HALT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] ir;
    logic              ir_ld;

    always_ff @(posedge pclock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (ir_ld)
                ir <= memdata;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_ld   = 1'b0;
        run     = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_n = FETCH;
            end
            FETCH: begin
                busy    = 1'b1;
                state_n = WAIT_MEM;
            end
            WAIT_MEM: begin
                // memory data for the address sampled at the FETCH edge is valid now
                busy    = 1'b1;
                ir_ld   = 1'b1;
                state_n = ISSUE;
            end
            ISSUE: begin
                busy    = 1'b1;
                run     = 1'b1;
                state_n = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (done) begin
                    // jump wins over the end-of-program halt
                    if (jump) begin
                        pc_n    = jumpaddr;
                        state_n = FETCH;
                    end else if (pc == LAST) begin
                        state_n = HALT;
                    end else begin
                        pc_n    = pc + ADDR_W'(1);
                        state_n = FETCH;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign memaddr = pc;
    assign instr   = ir;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: random execution traffic checked against
// an instruction-level model of the program counter and memory.
module tb_fetch_sequencer;

    logic        pclock;
    logic        resetn;
    logic        start;
    logic [4:0]  memaddr;
    logic [15:0] memdata;
    logic [15:0] instr;
    logic        run;
    logic        done;
    logic        jump;
    logic [4:0]  jumpaddr;
    logic        busy;
    logic        halted;

    logic [15:0] mem [32];

    int          checks   = 0;
    int          failures = 0;

    logic [4:0]  pc_m;
    bit          halted_m;

    fetch_sequencer #(.ADDR_W(5), .DATA_W(16), .LAST_ADDR(31)) dut (
        .pclock   (pclock),
        .resetn   (resetn),
        .start    (start),
        .memaddr  (memaddr),
        .memdata  (memdata),
        .instr    (instr),
        .run      (run),
        .done     (done),
        .jump     (jump),
        .jumpaddr (jumpaddr),
        .busy     (busy),
        .halted   (halted)
    );

    initial pclock = 1'b0;
    always #5 pclock = ~pclock;

    // synchronous instruction memory, one cycle read latency
    always @(posedge pclock) memdata <= mem[memaddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits for the Run pulse after a Start/Done sample edge; it must be the 3rd cycle.
    task automatic wait_run(input string tag);
        int cnt  = 0;
        bit seen = 0;
        while (cnt < 8 && !seen) begin
            @(negedge pclock);
            cnt++;
            start = 1'b0;
            done  = 1'b0;
            jump  = 1'b0;
            if (run) seen = 1;
        end
        chk({tag, "_lat"}, seen ? 32'(cnt) : 32'd99, 32'd3);
        if (seen) begin
            chk({tag, "_instr"}, 32'(instr), 32'(mem[pc_m]));
            chk({tag, "_addr"}, 32'(memaddr), 32'(pc_m));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    // Called at the negedge where Run is high; completes the instruction.
    task automatic exec_instr(input int dly, input bit jmp, input logic [4:0] ja,
                              input bit early, input bit noise);
        if (early) begin
            // Done already high in ISSUE must be ignored there, accepted in EXEC
            done = 1'b1; jump = jmp; jumpaddr = ja;
            @(negedge pclock);
            chk("early_run", 32'(run), 32'd0);
            chk("early_addr", 32'(memaddr), 32'(pc_m));
        end else begin
            @(negedge pclock);
            chk("exec_run", 32'(run), 32'd0);
            for (int i = 0; i < dly; i++) begin
                jump     = noise;
                jumpaddr = 5'($urandom_range(31));
                @(negedge pclock);
                chk("exec_instr", 32'(instr), 32'(mem[pc_m]));
                chk("exec_addr", 32'(memaddr), 32'(pc_m));
            end
            done = 1'b1; jump = jmp; jumpaddr = ja;
        end
        if (jmp)             pc_m = ja;
        else if (pc_m == 31) halted_m = 1;
        else                 pc_m = pc_m + 5'd1;
        if (halted_m) begin
            @(negedge pclock);
            done = 1'b0; jump = 1'b0;
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_busy", 32'(busy), 32'd0);
            chk("halt_addr", 32'(memaddr), 32'd31);
            for (int i = 0; i < 6; i++) begin
                start    = 1'($urandom_range(1));
                done     = 1'($urandom_range(1));
                jump     = 1'($urandom_range(1));
                jumpaddr = 5'($urandom_range(31));
                @(negedge pclock);
                chk("halt_run", 32'(run), 32'd0);
                chk("halt_stay", 32'(halted), 32'd1);
                chk("halt_pc", 32'(memaddr), 32'd31);
            end
            start = 1'b0; done = 1'b0; jump = 1'b0;
        end else begin
            wait_run("next");
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; done = 1'b0; jump = 1'b0; jumpaddr = '0;
        for (int k = 0; k < 32; k++) mem[k] = 16'($urandom);
        mem[0] = 16'h1234;
        mem[7] = 16'hbeef;
        pc_m = '0; halted_m = 0;
        repeat (2) @(negedge pclock);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_addr", 32'(memaddr), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge pclock);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        wait_run("first");

        // random traffic, halt avoided by forcing a jump at the last address
        for (int n = 0; n < 40; n++) begin
            bit jmp;
            jmp = ($urandom_range(3) == 0) || (pc_m == 5'd31);
            exec_instr(int'($urandom_range(3)), jmp, 5'($urandom_range(31)),
                       1'($urandom_range(4) == 0), 1'($urandom_range(1)));
        end

        // jump at PC=4 to 20, with a Done-less Jump pulse beforehand
        exec_instr(0, 1, 5'd4, 0, 0);
        exec_instr(2, 1, 5'd20, 0, 1);
        // jump wins over halt at the last address
        exec_instr(0, 1, 5'd31, 0, 0);
        exec_instr(1, 1, 5'd2, 0, 0);
        chk("no_halt", 32'(halted), 32'd0);
        exec_instr(0, 1, 5'd7, 0, 0);

        // asynchronous reset mid-EXEC at PC=7
        chk("pc7_instr", 32'(instr), 32'h0000beef);
        @(negedge pclock);
        #2 resetn = 1'b0;
        #1;
        chk("arst_run", 32'(run), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_instr", 32'(instr), 32'd0);
        chk("arst_addr", 32'(memaddr), 32'd0);
        for (int k = 0; k < 32; k++) mem[k] = 16'(k);
        pc_m = '0;
        @(negedge pclock);
        // Start on the first edge after reset release is sampled normally
        resetn = 1'b1;
        start  = 1'b1;
        wait_run("restart");

        // straight-line program through the final address into halt
        for (int n = 0; n < 32; n++)
            exec_instr(int'($urandom_range(2)), 0, 5'd0, 1'($urandom_range(3) == 0), 0);
        chk("end_halted", 32'(halted_m), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the program-counter and memory-address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the instruction width.
REQ-003 Parameter LAST_ADDR, default 31, SHALL set the final instruction address before halt.
REQ-004 PClock  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 Resetn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 Start  in  1  SHALL be the level request to begin execution, sampled only in IDLE.
REQ-007 MemAddr  out  ADDR_W  SHALL drive the synchronous instruction memory read address.
REQ-008 MemData  in  DATA_W  SHALL carry the memory read data, valid one cycle after the address is sampled.
REQ-009 Instr  out  DATA_W  SHALL present the instruction register to the control unit.
REQ-010 Run  out  1  SHALL be a one-cycle pulse meaning Instr is valid and execution may begin.
REQ-011 Done  in  1  SHALL be the control unit's completion indication, sampled only in EXEC.
REQ-012 Jump  in  1  SHALL request a PC load from JumpAddr, qualified by Done.
REQ-013 JumpAddr  in  ADDR_W  SHALL be the jump target.
REQ-014 Busy  out  1  SHALL be high in FETCH, WAIT_MEM, ISSUE and EXEC.
REQ-015 Halted  out  1  SHALL be high only in HALT.

Function
REQ-016 The block SHALL implement a five-plus-one state FSM: IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, HALT.
REQ-017 MemAddr SHALL equal PC combinationally at all times.
REQ-018 IDLE: when Start=1, the next state SHALL be FETCH; otherwise it SHALL stay in IDLE.
REQ-019 FETCH SHALL last exactly one cycle (memory samples MemAddr at its closing edge) and SHALL then go to WAIT_MEM.
REQ-020 WAIT_MEM SHALL last exactly one cycle; at its closing edge the IR SHALL load MemData and the next state SHALL be ISSUE.
REQ-021 ISSUE SHALL assert Run=1 for exactly one cycle and SHALL then go to EXEC unconditionally; Done in ISSUE SHALL be ignored.
REQ-022 EXEC SHALL hold Run=0 and Instr stable, and SHALL remain in EXEC while Done=0.
REQ-023 EXEC with Done=1 and Jump=1 SHALL set PC<=JumpAddr and go to FETCH; Jump SHALL take priority over halt.
REQ-024 EXEC with Done=1, Jump=0 and PC==LAST_ADDR SHALL go to HALT with PC unchanged.
REQ-025 EXEC with Done=1, Jump=0 and PC!=LAST_ADDR SHALL set PC<=PC+1 (modulo 2^ADDR_W) and go to FETCH.
REQ-026 Jump while Done=0, or in any state other than EXEC, SHALL be ignored.
REQ-027 HALT SHALL be terminal until reset; Start, Done and Jump SHALL be ignored there.
REQ-028 Latency: the Start sample edge to Run high SHALL be 3 cycles (FETCH, WAIT_MEM, ISSUE); the Done sample edge to the next Run SHALL also be 3 cycles.
REQ-029 Instr SHALL change only at the WAIT_MEM closing edge, and PC only on the EXEC Done edge.

Reset
REQ-030 Resetn=0 SHALL immediately, independent of PClock, force state=IDLE, PC=0, IR=0, Run=0, Busy=0, Halted=0.
REQ-031 Reset asserted in any state, including mid-EXEC or mid-WAIT_MEM, SHALL abort the instruction with no PC increment; after release the block SHALL wait in IDLE for Start.
REQ-032 On the first edge after Resetn rises, Start SHALL be sampled normally.

Verification
REQ-033 Reset, then Start=1 with mem[0]=16'h1234 -> Run high for exactly one cycle on the 3rd edge after Start, Instr=16'h1234, MemAddr=0.
REQ-034 Done pulses after each Run with mem[k]=k -> Instr sequence 0,1,2,...,31 in order; after the Done at PC=31, Halted=1, Busy=0, and Run is never asserted again.
REQ-035 At PC=4, Done=1 with Jump=1 and JumpAddr=20 -> next MemAddr=20, Instr=mem[20]; a Jump pulse with Done=0 leaves PC=4.
REQ-036 At PC=31, Done=1 with Jump=1 and JumpAddr=2 -> no halt, PC=2, Run follows 3 cycles later.
REQ-037 Resetn pulsed low mid-EXEC at PC=7 -> all outputs go to reset values asynchronously (before the next edge); after Start, fetch restarts at PC=0.
REQ-038 Done held high through ISSUE -> it is ignored in ISSUE and accepted on the first EXEC cycle; exactly one PC increment per Run.
